// File: rtl/pcm_tone_meter.sv
// rtl/pcm_tone_meter.sv - hysteretic zero-crossing tone period and amplitude meter
// Measures samples between rising events and the signed peaks seen across each cycle.
module pcm_tone_meter #(
  parameter int C_pcm_bits    = 12,
  parameter int C_period_bits = 16,
  parameter int C_hyst        = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic signed [C_pcm_bits-1:0]    pcm,
  input  logic                            pcm_valid,
  output logic        [C_period_bits-1:0] period,
  output logic signed [C_pcm_bits-1:0]    peak_max,
  output logic signed [C_pcm_bits-1:0]    peak_min,
  output logic        [C_pcm_bits-1:0]    p2p,
  output logic                            meas_valid,
  output logic                            timeout
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_NEG       = 3'd1,
    S_POS_FIRST = 3'd2,
    S_POS       = 3'd3,
    S_NEG_MEAS  = 3'd4
  } state_t;

  localparam logic signed [C_pcm_bits-1:0] HYST_P  = C_pcm_bits'(C_hyst);
  localparam logic signed [C_pcm_bits-1:0] HYST_N  = -HYST_P;
  localparam logic [C_period_bits-1:0]     CNT_MAX = '1;
  localparam logic [C_period_bits-1:0]     CNT_ONE = C_period_bits'(1);

  state_t state_q, state_d;

  logic        [C_period_bits-1:0] cnt_q, cnt_d, cnt_inc;
  logic signed [C_pcm_bits-1:0]    max_q, max_d, min_q, min_d;
  logic signed [C_pcm_bits-1:0]    run_max, run_min;
  logic        [C_period_bits-1:0] period_q, period_d;
  logic signed [C_pcm_bits-1:0]    pmax_q, pmax_d, pmin_q, pmin_d;
  logic        [C_pcm_bits-1:0]    p2p_q, p2p_d, p2p_w;
  logic                            meas_valid_q, meas_valid_d, timeout_q, timeout_d;

  logic rise, fall, sat;
  logic load, accum, meas_evt, tmo_evt;

  assign rise    = pcm_valid && (pcm >= HYST_P);
  assign fall    = pcm_valid && (pcm <= HYST_N);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign sat     = (cnt_inc == CNT_MAX);
  assign run_max = (pcm > max_q) ? pcm : max_q;
  assign run_min = (pcm < min_q) ? pcm : min_q;
  // Low bits of the (C_pcm_bits+1)-bit difference; the result always fits unsigned.
  assign p2p_w   = run_max - run_min;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (pcm_valid) begin
      case (state_q)
        S_IDLE:      if (fall) state_d = S_NEG; else if (rise) state_d = S_POS_FIRST;
        S_POS_FIRST: if (fall) state_d = S_NEG;
        S_NEG:       if (rise) state_d = S_POS;
        S_POS:       if (sat) state_d = S_IDLE; else if (fall) state_d = S_NEG_MEAS;
        S_NEG_MEAS:  if (rise) state_d = S_POS; else if (sat) state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    load     = 1'b0;
    accum    = 1'b0;
    meas_evt = 1'b0;
    tmo_evt  = 1'b0;
    if (pcm_valid) begin
      case (state_q)
        S_NEG: load = rise;
        S_POS: begin
          if (sat) tmo_evt = 1'b1;
          else     accum   = 1'b1;
        end
        S_NEG_MEAS: begin
          if (rise) begin
            meas_evt = 1'b1;
            load     = 1'b1;
          end else if (sat) begin
            tmo_evt = 1'b1;
          end else begin
            accum = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    max_d        = max_q;
    min_d        = min_q;
    period_d     = period_q;
    pmax_d       = pmax_q;
    pmin_d       = pmin_q;
    p2p_d        = p2p_q;
    meas_valid_d = meas_evt;
    timeout_d    = tmo_evt;
    if (load) begin
      cnt_d = CNT_ONE;
      max_d = pcm;
      min_d = pcm;
    end else if (accum) begin
      cnt_d = cnt_inc;
      max_d = run_max;
      min_d = run_min;
    end else if (tmo_evt) begin
      cnt_d = '0;
    end
    // period takes the count before the rising sample is added
    if (meas_evt) begin
      period_d = cnt_q;
      pmax_d   = run_max;
      pmin_d   = run_min;
      p2p_d    = p2p_w;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      max_q        <= '0;
      min_q        <= '0;
      period_q     <= '0;
      pmax_q       <= '0;
      pmin_q       <= '0;
      p2p_q        <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      max_q        <= max_d;
      min_q        <= min_d;
      period_q     <= period_d;
      pmax_q       <= pmax_d;
      pmin_q       <= pmin_d;
      p2p_q        <= p2p_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign period     = period_q;
  assign peak_max   = pmax_q;
  assign peak_min   = pmin_q;
  assign p2p        = p2p_q;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pcm_tone_meter.sv
// tb/tb_pcm_tone_meter.sv - directed vector bench for pcm_tone_meter
module tb_pcm_tone_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic signed [11:0] pcm;
  logic               pcm_valid;

  logic        [15:0] period;
  logic signed [11:0] peak_max, peak_min;
  logic        [11:0] p2p;
  logic               meas_valid, timeout;

  logic        [7:0]  period8;
  logic signed [11:0] peak_max8, peak_min8;
  logic        [11:0] p2p8;
  logic               meas_valid8, timeout8;

  pcm_tone_meter dut (
    .clk(clk), .reset(reset), .pcm(pcm), .pcm_valid(pcm_valid),
    .period(period), .peak_max(peak_max), .peak_min(peak_min), .p2p(p2p),
    .meas_valid(meas_valid), .timeout(timeout)
  );

  pcm_tone_meter #(.C_period_bits(8)) dut8 (
    .clk(clk), .reset(reset), .pcm(pcm), .pcm_valid(pcm_valid),
    .period(period8), .peak_max(peak_max8), .peak_min(peak_min8), .p2p(p2p8),
    .meas_valid(meas_valid8), .timeout(timeout8)
  );

  int nvec = 0;
  int nerr = 0;
  int mv_cnt = 0, to_cnt = 0, mv8_cnt = 0, to8_cnt = 0;

  always @(negedge clk) begin
    if (meas_valid)  mv_cnt  <= mv_cnt + 1;
    if (timeout)     to_cnt  <= to_cnt + 1;
    if (meas_valid8) mv8_cnt <= mv8_cnt + 1;
    if (timeout8)    to8_cnt <= to8_cnt + 1;
  end

  typedef struct {
    string name;
    int hi; int hi_n; int lo; int lo_n; int cycles; int gap;
    int e_per; int e_max; int e_min; int e_p2p; int e_meas;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input int s, input int gap);
    pcm       = 12'(s);
    pcm_valid = 1'b1;
    @(posedge clk); #1;
    pcm_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    pcm_valid = 1'b0;
    pcm       = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b_mv, b_to, b_mv8, b_to8;
    vec_t v;

    vt[0] = '{"sq1000",  1000, 50, -1000, 50, 3, 0, 100, 1000, -1000, 2000, 2};
    vt[1] = '{"slow4",   1000, 10, -1000, 10, 3, 3,  20, 1000, -1000, 2000, 2};
    vt[2] = '{"extreme", 2047,  8, -2048,  8, 4, 0,  16, 2047, -2048, 4095, 3};
    vt[3] = '{"hystedge",  16,  3,   -16,  5, 4, 0,   8,   16,   -16,   32, 3};
    vt[4] = '{"fast",     500,  1,  -700,  1, 5, 0,   2,  500,  -700, 1200, 4};

    reset = 1'b1; pcm_valid = 1'b0; pcm = '0;
    @(posedge clk); #1;
    chk("rst_period",  int'(period),   0);
    chk("rst_max",     int'(peak_max), 0);
    chk("rst_min",     int'(peak_min), 0);
    chk("rst_p2p",     int'(p2p),      0);
    chk("rst_mv",      int'(meas_valid), 0);
    chk("rst_to",      int'(timeout),  0);

    // full-swing square wave with strobes toggling while reset is held
    b_mv = mv_cnt; b_to = to_cnt;
    for (int k = 0; k < 80; k++) begin
      pcm       = (((k / 4) % 2) == 0) ? 12'sd2047 : -12'sd2048;
      pcm_valid = k[0];
      @(posedge clk); #1;
    end
    settle();
    chk("rsthold_mv",     mv_cnt - b_mv, 0);
    chk("rsthold_to",     to_cnt - b_to, 0);
    chk("rsthold_period", int'(period), 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      v = vt[i];
      do_reset();
      b_mv = mv_cnt; b_to = to_cnt;
      for (int c = 0; c < v.cycles; c++) begin
        repeat (v.hi_n) send(v.hi, v.gap);
        repeat (v.lo_n) send(v.lo, v.gap);
      end
      send(v.hi, v.gap);
      settle();
      chk({v.name, "_nmeas"},  mv_cnt - b_mv, v.e_meas);
      chk({v.name, "_nto"},    to_cnt - b_to, 0);
      chk({v.name, "_period"}, int'(period),   v.e_per);
      chk({v.name, "_max"},    int'(peak_max), v.e_max);
      chk({v.name, "_min"},    int'(peak_min), v.e_min);
      chk({v.name, "_p2p"},    int'(p2p),      v.e_p2p);
    end

    // in-band chatter must not trigger; the exact threshold must
    do_reset();
    b_mv = mv_cnt;
    repeat (5) send(1000, 0);
    repeat (5) send(-1000, 0);
    repeat (5) send(1000, 0);
    repeat (5) send(-1000, 0);
    for (int k = 0; k < 200; k++) send(((k % 2) == 0) ? 15 : -15, 0);
    settle();
    chk("chatter_nmeas", mv_cnt - b_mv, 0);
    pcm = 12'sd16; pcm_valid = 1'b1;
    @(posedge clk); #1;
    chk("hyst_latency", int'(meas_valid), 1);
    pcm_valid = 1'b0;
    @(posedge clk); #1;
    chk("hyst_width",  int'(meas_valid), 0);
    chk("hyst_period", int'(period),   210);
    chk("hyst_max",    int'(peak_max), 1000);
    chk("hyst_min",    int'(peak_min), -1000);
    chk("hyst_p2p",    int'(p2p),      2000);

    // saturation of the 8-bit counter
    do_reset();
    b_mv8 = mv8_cnt; b_to8 = to8_cnt;
    repeat (2) send(500, 0);
    repeat (2) send(-500, 0);
    send(500, 0);
    repeat (253) send(500, 0);
    settle();
    chk("tmo_early", to8_cnt - b_to8, 0);
    pcm = 12'sd500; pcm_valid = 1'b1;
    @(posedge clk); #1;
    chk("tmo_pulse", int'(timeout8), 1);
    pcm_valid = 1'b0;
    @(posedge clk); #1;
    chk("tmo_width", int'(timeout8), 0);
    settle();
    chk("tmo_count",  to8_cnt - b_to8, 1);
    chk("tmo_nmeas",  mv8_cnt - b_mv8, 0);
    chk("tmo_period", int'(period8), 0);

    send(-500, 0);
    send(500, 0);
    send(-500, 0);
    send(500, 0);
    settle();
    chk("post_tmo_nmeas",  mv8_cnt - b_mv8, 1);
    chk("post_tmo_period", int'(period8),   2);
    chk("post_tmo_max",    int'(peak_max8), 500);
    chk("post_tmo_min",    int'(peak_min8), -500);
    chk("post_tmo_p2p",    int'(p2p8),      1000);

    // reset on the same edge as a measuring rising sample
    send(-500, 0);
    reset = 1'b1; pcm = 12'sd500; pcm_valid = 1'b1;
    @(posedge clk); #1;
    chk("rstrise_mv",     int'(meas_valid8), 0);
    chk("rstrise_period", int'(period8),     0);
    chk("rstrise_max",    int'(peak_max8),   0);
    chk("rstrise_min",    int'(peak_min8),   0);
    chk("rstrise_p2p",    int'(p2p8),        0);
    reset = 1'b0; pcm_valid = 1'b0;
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
